// File: rtl/smart_scales_session.sv
// Weigh-in session controller: collects SAMPLES stable load-cell samples, averages them and
// classifies BMI without a divider. Define SMART_SCALES_HISTORY_EN to add the per-user trend table.
module smart_scales_session #(
  parameter int  USERS    = 4,
  parameter int  SAMPLES  = 4,
  parameter int  WEIGHT_W = 9,
  parameter int  HEIGHT_W = 8,
  parameter int  STAB_TOL = 2,
  parameter int  TIMEOUT  = 1000,
  localparam int UID_W    = (USERS > 1) ? $clog2(USERS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [UID_W-1:0]    user_id,
  input  logic [HEIGHT_W-1:0] height,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WEIGHT_W-1:0] s_weight,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [UID_W-1:0]    r_user,
  output logic [WEIGHT_W-1:0] r_weight,
  output logic                r_under,
  output logic                r_normal,
  output logic                r_over,
  output logic                r_timeout,
  output logic [1:0]          r_trend,
  output logic                busy
);

  localparam int LOG2S = $clog2(SAMPLES);
  localparam int ACC_W = WEIGHT_W + LOG2S;
  localparam int CNT_W = LOG2S + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HSQ_W = 2 * HEIGHT_W;
  localparam int CMP_W = (WEIGHT_W + 17 > HSQ_W + 8) ? WEIGHT_W + 17 : HSQ_W + 8;

  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_CALC1, S_CALC2, S_OUT} state_t;

  state_t              r_state, w_next;
  logic [UID_W-1:0]    r_uid;
  logic [HEIGHT_W-1:0] r_height;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [TMO_W-1:0]    r_tmo;
  logic [WEIGHT_W-1:0] r_prev;
  logic [WEIGHT_W-1:0] r_avg;
  logic [HSQ_W-1:0]    r_hsq;

  logic                w_hs, w_stable, w_done, w_tmo;
  logic [WEIGHT_W-1:0] w_diff;
  logic [CMP_W-1:0]    w_avg_1e5, w_avg_400, w_hsq_185, w_hsq;
  logic                w_under, w_over;
  logic [1:0]          w_trend;

  assign s_ready  = (r_state == S_ACQ);
  assign busy     = (r_state != S_IDLE);

  assign w_hs     = s_valid && s_ready;
  assign w_diff   = (s_weight >= r_prev) ? (s_weight - r_prev) : (r_prev - s_weight);
  assign w_stable = (r_cnt == '0) || (w_diff <= WEIGHT_W'(STAB_TOL));
  assign w_done   = w_hs && w_stable && (r_cnt == CNT_W'(SAMPLES - 1));
  // A completing handshake in the last allowed cycle beats the timeout.
  assign w_tmo    = (r_tmo == TMO_W'(TIMEOUT - 1)) && !w_done;

  // BMI thresholds rearranged as cross-multiplications at full width.
  assign w_avg_1e5 = CMP_W'(r_avg) * CMP_W'(100000);
  assign w_avg_400 = CMP_W'(r_avg) * CMP_W'(400);
  assign w_hsq_185 = CMP_W'(r_hsq) * CMP_W'(185);
  assign w_hsq     = CMP_W'(r_hsq);
  assign w_under   = (w_avg_1e5 < w_hsq_185);
  assign w_over    = (w_avg_400 >= w_hsq);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && (height != '0)) w_next = S_ACQ;
      S_ACQ: begin
        if (w_done)     w_next = S_CALC1;
        else if (w_tmo) w_next = S_OUT;
      end
      S_CALC1: w_next = S_CALC2;
      S_CALC2: w_next = S_OUT;
      S_OUT:   if (r_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uid     <= '0;
      r_height  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_prev    <= '0;
      r_avg     <= '0;
      r_hsq     <= '0;
      r_valid   <= 1'b0;
      r_user    <= '0;
      r_weight  <= '0;
      r_under   <= 1'b0;
      r_normal  <= 1'b0;
      r_over    <= 1'b0;
      r_timeout <= 1'b0;
      r_trend   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (height != '0)) begin
            r_uid    <= user_id;
            r_height <= height;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_tmo    <= '0;
          end
        end
        S_ACQ: begin
          r_tmo <= r_tmo + TMO_W'(1);
          if (w_hs) begin
            r_prev <= s_weight;
            if (w_stable) begin
              r_acc <= r_acc + ACC_W'(s_weight);
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_acc <= ACC_W'(s_weight);
              r_cnt <= CNT_W'(1);
            end
          end
          if (w_tmo) begin
            r_valid   <= 1'b1;
            r_user    <= r_uid;
            r_weight  <= '0;
            r_under   <= 1'b0;
            r_normal  <= 1'b0;
            r_over    <= 1'b0;
            r_timeout <= 1'b1;
            r_trend   <= 2'b00;
          end
        end
        S_CALC1: begin
          r_avg <= WEIGHT_W'(r_acc >> LOG2S);
          r_hsq <= HSQ_W'(r_height) * HSQ_W'(r_height);
        end
        S_CALC2: begin
          r_valid   <= 1'b1;
          r_user    <= r_uid;
          r_weight  <= r_avg;
          r_under   <= w_under;
          r_normal  <= !w_under && !w_over;
          r_over    <= w_over;
          r_timeout <= 1'b0;
          r_trend   <= w_trend;
        end
        S_OUT: if (r_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SMART_SCALES_HISTORY_EN
  logic [WEIGHT_W-1:0] r_hist_w [USERS];
  logic [USERS-1:0]    r_hist_v;
  logic                w_hist_wr;

  assign w_hist_wr = r_valid && r_ready && !r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_hist_v         <= '0;
    else if (w_hist_wr) r_hist_v[r_user] <= 1'b1;
  end

  // NOTE: the weight array has no reset; r_hist_v qualifies every read.
  always_ff @(posedge clk) begin
    if (w_hist_wr) r_hist_w[r_user] <= r_weight;
  end

  always_comb begin
    w_trend = 2'b00;
    if (r_hist_v[r_uid]) begin
      if (r_avg > r_hist_w[r_uid])      w_trend = 2'b01;
      else if (r_avg < r_hist_w[r_uid]) w_trend = 2'b10;
      else                              w_trend = 2'b11;
    end
  end
`else
  assign w_trend = 2'b00;
`endif

endmodule

// File: tb/tb_smart_scales_session.sv
// Self-checking bench for smart_scales_session: directed cases plus randomized sessions
// checked against a queue/real-arithmetic model of the weigh-in rules.
module tb_smart_scales_session;

  localparam int USERS    = 4;
  localparam int SAMPLES  = 4;
  localparam int WEIGHT_W = 9;
  localparam int HEIGHT_W = 8;
  localparam int STAB_TOL = 2;
  localparam int TIMEOUT  = 1000;
  localparam int UID_W    = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [UID_W-1:0]    user_id = '0;
  logic [HEIGHT_W-1:0] height = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [WEIGHT_W-1:0] s_weight = '0;
  logic                r_valid;
  logic                r_ready = 1'b0;
  logic [UID_W-1:0]    r_user;
  logic [WEIGHT_W-1:0] r_weight;
  logic                r_under, r_normal, r_over, r_timeout;
  logic [1:0]          r_trend;
  logic                busy;

  smart_scales_session #(
    .USERS(USERS), .SAMPLES(SAMPLES), .WEIGHT_W(WEIGHT_W), .HEIGHT_W(HEIGHT_W),
    .STAB_TOL(STAB_TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .user_id(user_id), .height(height),
    .s_valid(s_valid), .s_ready(s_ready), .s_weight(s_weight),
    .r_valid(r_valid), .r_ready(r_ready), .r_user(r_user), .r_weight(r_weight),
    .r_under(r_under), .r_normal(r_normal), .r_over(r_over), .r_timeout(r_timeout),
    .r_trend(r_trend), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int user;
    int weight;
    bit timeout;
    bit under;
    bit normal;
    bit over;
    int trend;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;

  int stim[$];
  int run_q[$];
  int hist_w [USERS];
  bit hist_v [USERS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Behavioural model: the current stable run is a queue; a sample that jumps more than
  // STAB_TOL from the previous one starts a new run.
  function automatic bit model_push(int w);
    int d;
    if (run_q.size() != 0) begin
      d = w - run_q[run_q.size()-1];
      if (d < 0) d = -d;
      if (d > STAB_TOL) run_q.delete();
    end
    run_q.push_back(w);
    return (run_q.size() == SAMPLES);
  endfunction

  function automatic res_t model_result(int uid, int h);
    res_t e;
    int   sum = 0;
    real  bmi;
    foreach (run_q[i]) sum += run_q[i];
    e.user    = uid;
    e.weight  = sum / SAMPLES;
    e.timeout = 1'b0;
    bmi       = real'(e.weight) * 10000.0 / (real'(h) * real'(h));
    e.under   = (bmi < 18.5);
    e.over    = (bmi >= 25.0);
    e.normal  = !e.under && !e.over;
    e.trend   = 0;
`ifdef SMART_SCALES_HISTORY_EN
    if (hist_v[uid]) e.trend = (e.weight > hist_w[uid]) ? 1 : (e.weight < hist_w[uid]) ? 2 : 3;
`endif
    return e;
  endfunction

  function automatic res_t timeout_result(int uid);
    res_t e;
    e.user = uid; e.weight = 0; e.timeout = 1'b1;
    e.under = 1'b0; e.normal = 1'b0; e.over = 1'b0; e.trend = 0;
    return e;
  endfunction

  task automatic start_session(input int uid, input int h);
    @(negedge clk);
    start = 1'b1; user_id = UID_W'(uid); height = HEIGHT_W'(h);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    run_q.delete();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic feed(input int w, output bit done);
    @(negedge clk);
    s_valid = 1'b1; s_weight = WEIGHT_W'(w);
    check("s_ready_in_acq", s_ready, 1);
    @(posedge clk);
    done = model_push(w);
  endtask

  task automatic check_result(input string tag, input res_t e);
    check({tag, "_valid"},   r_valid,   1);
    check({tag, "_user"},    r_user,    e.user);
    check({tag, "_weight"},  r_weight,  e.weight);
    check({tag, "_timeout"}, r_timeout, e.timeout);
    check({tag, "_under"},   r_under,   e.under);
    check({tag, "_normal"},  r_normal,  e.normal);
    check({tag, "_over"},    r_over,    e.over);
    if (!e.timeout) check({tag, "_trend"}, r_trend, e.trend);
  endtask

  // Holds r_ready low for dly cycles (optionally pulsing start), then accepts the result.
  task automatic accept(input int dly, input res_t e, input bit poke_start);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (poke_start) begin
        start = (i >= 2 && i < 5); height = HEIGHT_W'(170);
      end
      check("hold_valid",  r_valid,  1);
      check("hold_weight", r_weight, e.weight);
      check("hold_busy",   busy,     1);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0; r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    check("valid_after_accept", r_valid, 0);
    check("idle_after_accept",  busy,    0);
    check("weight_kept",        r_weight, e.weight);
    if (!e.timeout) begin
      hist_w[e.user] = e.weight;
      hist_v[e.user] = 1'b1;
    end
  endtask

  // Runs one completing session from the global stim queue.
  task automatic run_session(input string tag, input int uid, input int h, input int dly,
                             input int pre_idle, input int gap_max, input bit poke_start);
    bit   done = 1'b0;
    int   lat;
    res_t e;
    start_session(uid, h);
    repeat (pre_idle) idle_cycle();
    foreach (stim[i]) begin
      repeat ($urandom_range(0, gap_max)) idle_cycle();
      feed(stim[i], done);
      if (done) break;
    end
    check({tag, "_completes"}, done, 1);
    e = model_result(uid, h);
    lat = 1;
    @(negedge clk);
    s_valid = 1'b0;
    check({tag, "_s_ready_drop"}, s_ready, 0);
    while (!r_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 3);
    check_result(tag, e);
    accept(dly, e, poke_start);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (hist_v[i]) hist_v[i] = 1'b0;
    run_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   done;
    int   cyc;
    res_t e;
    int   base;

    do_reset();
    #1;
    check("rst_busy",    busy,     0);
    check("rst_s_ready", s_ready,  0);
    check("rst_r_valid", r_valid,  0);
    check("rst_weight",  r_weight, 0);
    check("rst_trend",   r_trend,  0);

    stim = '{70, 70, 70, 70};          run_session("t1", 0, 175, 0, 0, 0, 0);
    stim = '{80, 80, 81, 79};          run_session("t2", 2, 160, 1, 0, 1, 0);
    stim = '{50, 50, 50, 50};          run_session("t3", 3, 180, 0, 0, 0, 0);
    stim = '{70, 75, 70, 70, 70, 70};  run_session("t4", 0, 175, 0, 0, 0, 0);
    stim = '{70, 70, 71, 71};          run_session("trunc", 2, 175, 0, 0, 0, 0);

    // start with zero height is ignored
    @(negedge clk);
    start = 1'b1; user_id = 1; height = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("h0_ignored", busy, 0);

    // timeout with no samples, then reset in the middle of a new acquisition
    start_session(3, 170);
    @(negedge clk);
    s_valid = 1'b0;
    cyc = 0;
    while (!r_valid && cyc < 1100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    check("tmo_cycles", cyc, TIMEOUT);
    e = timeout_result(3);
    check_result("tmo", e);
    accept(0, e, 0);

    start_session(1, 170);
    feed(70, done);
    feed(70, done);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",    busy,      0);
    check("midrst_valid",   r_valid,   0);
    check("midrst_s_ready", s_ready,   0);
    check("midrst_timeout", r_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (hist_v[i]) hist_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_result", r_valid, 0);

    // a completing handshake in the last ACQ cycle wins over the timeout
    stim = '{70, 70, 70, 70};
    run_session("last_hs", 0, 175, 0, TIMEOUT - SAMPLES, 0, 0);

    // one cycle later the run is incomplete and the session times out
    start_session(2, 175);
    repeat (TIMEOUT - SAMPLES + 1) idle_cycle();
    for (int i = 0; i < SAMPLES - 1; i++) feed(70, done);
    @(negedge clk);
    s_valid = 1'b0;
    e = timeout_result(2);
    check_result("late_tmo", e);
    accept(0, e, 0);

    // output hold with start pulses ignored; trend for user 1
    stim = '{70, 70, 70, 70};  run_session("t6a", 1, 175, 10, 0, 0, 1);
    stim = '{72, 72, 72, 72};  run_session("t6b", 1, 175, 0, 0, 0, 0);

    // BMI class boundaries
    stim = '{74, 74, 74, 74};     run_session("b185",  0, 200, 0, 0, 0, 0);
    stim = '{73, 73, 73, 73};     run_session("b184",  0, 200, 0, 0, 0, 0);
    stim = '{100, 100, 100, 100}; run_session("b25",   2, 200, 0, 0, 0, 0);
    stim = '{99, 99, 99, 99};     run_session("b2475", 2, 200, 0, 0, 0, 0);
    stim = '{64, 64, 64, 64};     run_session("b25b",  3, 160, 0, 0, 0, 0);

    for (int s = 0; s < 30; s++) begin
      stim.delete();
      base = $urandom_range(35, 160);
      for (int i = 0; i < 24; i++) begin
        if (i >= 16)                     stim.push_back(base);
        else if ($urandom_range(0, 4) == 0) stim.push_back(base + $urandom_range(0, 20));
        else                             stim.push_back(base + $urandom_range(0, 4) - 2);
      end
      run_session("rnd", $urandom_range(0, USERS - 1), $urandom_range(120, 210),
                  $urandom_range(0, 3), 0, 2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
